// File: rtl/shared_add_arb_if.sv
// Request/result bundle for the shared add/subtract arbiter.
// The master side drives requests and consumes results; the slave side is the arbiter.
interface shared_add_arb_if #(
    parameter int N    = 26,
    parameter int NREQ = 3
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_sub;
    logic              res_valid;
    logic              res_ready;
    logic [N-1:0]      res_sum;
    logic              res_cout;
    logic              res_ovf;
    logic [1:0]        res_id;
    logic [15:0]       ops_done;

    modport master (
        output req_valid, req_a, req_b, req_sub, res_ready,
        input  req_ready, res_valid, res_sum, res_cout, res_ovf, res_id, ops_done
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, res_ready,
        output req_ready, res_valid, res_sum, res_cout, res_ovf, res_id, ops_done
    );
endinterface

// File: rtl/shared_add_arb.sv
// Round-robin arbiter feeding three axis requesters into one shared N-bit
// adder/subtractor, with a single registered result slot and handshake counter.
module shared_add_arb #(
    parameter int N    = 26,
    parameter int NREQ = 3
) (
    input  logic             clk,
    input  logic             rst,
    shared_add_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        GRANT_X = 2'd0,
        GRANT_Y = 2'd1,
        GRANT_Z = 2'd2
    } axis_t;

    axis_t           last_grant_q;
    axis_t           last_grant_d;

    logic            res_valid_q;
    logic [N-1:0]    res_sum_q;
    logic            res_cout_q;
    logic            res_ovf_q;
    logic [1:0]      res_id_q;
    logic [15:0]     ops_done_q;

    logic            accept;
    logic            found;
    logic [1:0]      gnt_idx;
    logic [NREQ-1:0] grant;

    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic            op_sub;
    logic [N-1:0]    sum;
    logic            carry;
    logic            ovf;

    // The result slot frees up in the same cycle it is consumed, so a new
    // request can be taken without a bubble.
    assign accept = !rst && (!res_valid_q || bus.res_ready);

    always_comb begin
        grant        = '0;
        found        = 1'b0;
        gnt_idx      = 2'(last_grant_q);
        last_grant_d = last_grant_q;
        for (int unsigned k = 1; k <= 3; k++) begin
            logic [1:0] idx;
            idx = 2'((32'(last_grant_q) + k) % 3);
            if (!found && accept && bus.req_valid[idx]) begin
                found        = 1'b1;
                grant[idx]   = 1'b1;
                gnt_idx      = idx;
                last_grant_d = axis_t'(idx);
            end
        end
    end

    // Single shared adder: subtraction is A + ~B + 1 through the carry-in.
    always_comb begin
        op_a   = bus.req_a[32'(gnt_idx)*N +: N];
        op_sub = bus.req_sub[gnt_idx];
        op_b   = op_sub ? ~bus.req_b[32'(gnt_idx)*N +: N] : bus.req_b[32'(gnt_idx)*N +: N];
        {carry, sum} = {1'b0, op_a} + {1'b0, op_b} + (N+1)'(op_sub);
        ovf    = (op_a[N-1] == op_b[N-1]) && (sum[N-1] != op_a[N-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_Z;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_id_q    <= '0;
            ops_done_q  <= '0;
        end else begin
            if (found) begin
                res_valid_q <= 1'b1;
                res_sum_q   <= sum;
                res_cout_q  <= carry;
                res_ovf_q   <= ovf;
                res_id_q    <= gnt_idx;
            end else if (bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
            if (res_valid_q && bus.res_ready) begin
                ops_done_q <= ops_done_q + 16'd1;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_cout  = res_cout_q;
    assign bus.res_ovf   = res_ovf_q;
    assign bus.res_id    = res_id_q;
    assign bus.ops_done  = ops_done_q;
endmodule

// File: tb/tb_shared_add_arb.sv
// Self-checking bench for shared_add_arb: directed vectors, corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_shared_add_arb;
    localparam int N = 26;
    localparam longint MOD  = longint'(1) << N;
    localparam longint HALF = longint'(1) << (N - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shared_add_arb_if #(.N(N), .NREQ(3)) bus ();

    shared_add_arb #(.N(N), .NREQ(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit          m_known = 0;
    bit          m_valid;
    logic [N-1:0] m_sum;
    bit          m_cout;
    bit          m_ovf;
    int          m_id;
    int          m_ops;
    int          m_last;
    int          last_g = -1;

    typedef struct {
        int           id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sub;
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic longint to_signed(input longint v);
        return (v >= HALF) ? v - MOD : v;
    endfunction

    function automatic void ref_op(input longint a, input longint b, input bit sub,
                                   output logic [N-1:0] s, output bit c, output bit o);
        longint r;
        longint sr;
        if (!sub) begin
            r  = a + b;
            c  = (r >= MOD);
            sr = to_signed(a) + to_signed(b);
        end else begin
            r  = a - b;
            c  = (a >= b);
            sr = to_signed(a) - to_signed(b);
        end
        s = N'(((r % MOD) + MOD) % MOD);
        o = (sr >= HALF) || (sr < -HALF);
    endfunction

    function automatic int exp_grant();
        if (rst || (m_valid && !bus.res_ready)) return -1;
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (m_last + k) % 3;
            if (bus.req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
        bus.req_a[i*N +: N] = a;
        bus.req_b[i*N +: N] = b;
        bus.req_sub[i]      = sub;
    endtask

    task automatic sample();
        int eg;
        @(negedge clk);
        if (m_known) begin
            eg = exp_grant();
            chk("req_ready", 64'(bus.req_ready), (eg < 0) ? 64'd0 : (64'd1 << eg));
            chk("res_valid", 64'(bus.res_valid), 64'(m_valid));
            chk("res_sum",   64'(bus.res_sum),   64'(m_sum));
            chk("res_cout",  64'(bus.res_cout),  64'(m_cout));
            chk("res_ovf",   64'(bus.res_ovf),   64'(m_ovf));
            chk("res_id",    64'(bus.res_id),    64'(m_id));
            chk("ops_done",  64'(bus.ops_done),  64'(m_ops));
        end
    endtask

    task automatic advance();
        int g;
        bit xfer;
        @(posedge clk);
        g = exp_grant();
        if (rst) begin
            m_known = 1; m_valid = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
            m_id = 0; m_ops = 0; m_last = 2; g = -1;
        end else begin
            xfer = m_valid && bus.res_ready;
            if (xfer) m_ops = (m_ops + 1) % 65536;
            if (g >= 0) begin
                logic [N-1:0] s;
                bit c, o;
                ref_op(longint'(bus.req_a[g*N +: N]), longint'(bus.req_b[g*N +: N]),
                       bus.req_sub[g], s, c, o);
                m_sum = s; m_cout = c; m_ovf = o; m_id = g;
                m_valid = 1; m_last = g;
            end else if (xfer) begin
                m_valid = 0;
            end
        end
        last_g = g;
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    logic [N-1:0] held_sum;

    initial begin
        tbl[0] = '{1, 26'h3FFFFFF, 26'h0000001, 1'b0, 26'h0000000, 1'b1, 1'b0};
        tbl[1] = '{2, 26'h1FFFFFF, 26'h0000001, 1'b0, 26'h2000000, 1'b0, 1'b1};
        tbl[2] = '{2, 26'h0000005, 26'h0000007, 1'b1, 26'h3FFFFFE, 1'b0, 1'b0};
        tbl[3] = '{0, 26'h2000000, 26'h0000001, 1'b1, 26'h1FFFFFF, 1'b1, 1'b1};
        tbl[4] = '{0, 26'h0000000, 26'h0000000, 1'b1, 26'h0000000, 1'b1, 1'b0};
        tbl[5] = '{1, 26'h1FFFFFF, 26'h1FFFFFF, 1'b0, 26'h3FFFFFE, 1'b0, 1'b1};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        bus.res_ready = 1'b0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("reset_res_valid", 64'(bus.res_valid), 64'd0);
        chk("reset_ops_done",  64'(bus.ops_done),  64'd0);
        chk("reset_res_sum",   64'(bus.res_sum),   64'd0);

        // Round-robin over all three with the consumer always ready
        for (int i = 0; i < 3; i++) set_req(i, N'(i + 1), N'(10), 1'b0);
        bus.req_valid = 3'b111;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [2:0] rr_exp;
            rr_exp = 3'b001 << (k % 3);
            sample();
            chk("rr_grant", 64'(bus.req_ready), 64'(rr_exp));
            advance();
        end

        // Directed arithmetic vectors, one requester at a time
        for (int t = 0; t < 6; t++) begin
            bus.req_valid = '0;
            set_req(tbl[t].id, tbl[t].a, tbl[t].b, tbl[t].sub);
            bus.req_valid[tbl[t].id] = 1'b1;
            bus.res_ready = 1'b1;
            cycle();
            bus.req_valid = '0;
            chk("vec_sum",  64'(bus.res_sum),  64'(tbl[t].sum));
            chk("vec_cout", 64'(bus.res_cout), 64'(tbl[t].cout));
            chk("vec_ovf",  64'(bus.res_ovf),  64'(tbl[t].ovf));
            chk("vec_id",   64'(bus.res_id),   64'(tbl[t].id));
            cycle();
        end

        // Backpressure: result held, no grants, then release without a bubble
        bus.res_ready = 1'b0;
        set_req(0, 26'h0001234, 26'h0000011, 1'b0);
        set_req(1, 26'h0000100, 26'h0000001, 1'b1);
        bus.req_valid = 3'b001;
        cycle();
        bus.req_valid = 3'b011;
        sample();
        chk("hold_ready", 64'(bus.req_ready), 64'd0);
        held_sum = bus.res_sum;
        chk("hold_valid", 64'(bus.res_valid), 64'd1);
        advance();
        sample();
        chk("hold_stable", 64'(bus.res_sum), 64'(held_sum));
        advance();
        bus.res_ready = 1'b1;
        sample();
        chk("release_grant", 64'(bus.req_ready), 64'b010);
        advance();
        chk("release_id", 64'(bus.res_id), 64'd1);
        chk("release_sum", 64'(bus.res_sum), 64'h00000FF);

        // Reset while a result is held and unconsumed
        bus.res_ready = 1'b0;
        bus.req_valid = 3'b000;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.req_valid = 3'b110;
        sample();
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_ops_done",  64'(bus.ops_done),  64'd0);
        chk("rst_first_grant", 64'(bus.req_ready), 64'b010);
        advance();
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        cycle();

        // Randomized traffic; requesters hold their request until granted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!bus.req_valid[i] || last_g == i) begin
                    bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_req(i, N'($urandom), N'($urandom), 1'($urandom));
                end
            end
            bus.res_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        // Counter wrap: run transfers until the model reaches 16'hFFFF
        bus.req_valid = 3'b111;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 70000 && m_ops != 16'hFFFF; c++) cycle();
        chk("ops_preload", 64'(bus.ops_done), 64'hFFFF);
        cycle();
        chk("ops_wrap", 64'(bus.ops_done), 64'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
